bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 127 ++++++++++++
 tb/tb_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared 16-bit tristate bus: one grantee at a time,
// bounded hold time, and guaranteed idle turnaround between owners.
//
//   state | meaning
//   IDLE  | bus free; arbitrate among active requests
//   SETUP | grant asserted, drivers still off (one cycle)
//   DRIVE | grantee drives the bus; hold counter running
//   TURN  | all drivers off for TURN_CYC cycles before next arbitration
module bus_arbiter #(
  parameter int N_SRC    = 4,
  parameter int MAX_HOLD = 16,
  parameter int TURN_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] gnt,
  output logic [N_SRC-1:0] T,
  output logic [1:0]       owner,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, SETUP, DRIVE, TURN} state_t;

  state_t             state, state_nxt;
  logic [1:0]         last_owner, last_nxt;
  logic [1:0]         owner_nxt;
  logic [7:0]         hold_cnt, hold_nxt;
  logic [2:0]         turn_cnt, turn_nxt;
  logic [N_SRC-1:0]   gnt_nxt, t_nxt;
  logic               busy_nxt, timeout_nxt;
  logic [1:0]         pick, idx;
  logic               found;

  // Search starts just above the previous owner, so it ends up lowest priority.
  always_comb begin
    pick  = last_owner;
    idx   = last_owner;
    found = 1'b0;
    for (int i = 1; i <= N_SRC; i++) begin
      idx = last_owner + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    last_nxt    = last_owner;
    hold_nxt    = hold_cnt;
    turn_nxt    = turn_cnt;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = pick;
          last_nxt  = pick;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (req[owner]) begin
          hold_nxt  = 8'd0;
          state_nxt = DRIVE;
        end else begin
          turn_nxt  = 3'(TURN_CYC - 1);
          state_nxt = TURN;
        end
      end
      DRIVE: begin
        // A release coinciding with the hold limit counts as a normal release.
        if (!req[owner]) begin
          turn_nxt  = 3'(TURN_CYC - 1);
          state_nxt = TURN;
        end else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
          turn_nxt    = 3'(TURN_CYC - 1);
          timeout_nxt = 1'b1;
          state_nxt   = TURN;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      TURN: begin
        if (turn_cnt == 3'd0) state_nxt = IDLE;
        else                  turn_nxt  = turn_cnt - 3'd1;
      end
      default: state_nxt = IDLE;
    endcase

    gnt_nxt  = '0;
    t_nxt    = '0;
    if (state_nxt == SETUP || state_nxt == DRIVE)
      gnt_nxt = N_SRC'(1) << owner_nxt;
    if (state_nxt == DRIVE)
      t_nxt = N_SRC'(1) << owner_nxt;
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 2'd3;
      owner      <= 2'd0;
      hold_cnt   <= 8'd0;
      turn_cnt   <= 3'd0;
      gnt        <= '0;
      T          <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_nxt;
      owner      <= owner_nxt;
      hold_cnt   <= hold_nxt;
      turn_cnt   <= turn_nxt;
      gnt        <= gnt_nxt;
      T          <= t_nxt;
      busy       <= busy_nxt;
      timeout    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: default instance plus a MAX_HOLD=4 instance
// for the short-hold timeout scenario; bus-safety rules monitored every cycle.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req4;
  logic [3:0] gnt, T, gnt4, T4;
  logic [1:0] owner, owner4;
  logic       busy, timeout, busy4, timeout4;
  logic [3:0] prev_t, prev_t4;
  logic [11:0] obs, obs4;
  int vectors = 0;
  int miscompares = 0;

  bus_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .T(T),
    .owner(owner), .busy(busy), .timeout(timeout)
  );

  bus_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .gnt(gnt4), .T(T4),
    .owner(owner4), .busy(busy4), .timeout(timeout4)
  );

  always #5 clk = ~clk;

  assign obs  = {gnt,  T,  owner,  busy,  timeout};
  assign obs4 = {gnt4, T4, owner4, busy4, timeout4};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus-safety rules checked on every falling edge.
  initial begin
    prev_t  = 4'b0000;
    prev_t4 = 4'b0000;
  end

  always @(negedge clk) begin
    vectors++;
    if (!($countones(T) <= 1 && (T & ~gnt) == 4'b0000 &&
          !(prev_t != 4'b0000 && T != 4'b0000 && T != prev_t))) begin
      miscompares++;
      $display("FAIL bus_rules dut: T=%b gnt=%b prev_T=%b", T, gnt, prev_t);
    end
    vectors++;
    if (!($countones(T4) <= 1 && (T4 & ~gnt4) == 4'b0000 &&
          !(prev_t4 != 4'b0000 && T4 != 4'b0000 && T4 != prev_t4))) begin
      miscompares++;
      $display("FAIL bus_rules dut4: T=%b gnt=%b prev_T=%b", T4, gnt4, prev_t4);
    end
    prev_t  = T;
    prev_t4 = T4;
  end

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    req4 = 4'b0000;
    #1;
    vectors++;
    if (obs !== 12'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", obs, 12'b0);
    end
    vectors++;
    if (obs4 !== 12'b0) begin
      miscompares++;
      $display("FAIL reset_state4: got %b want %b", obs4, 12'b0);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    req = 4'b0001;
    tick();
    vectors++;
    if (obs !== {4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_setup: got %b want %b", obs, {4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0});
    end
    for (int e = 2; e <= 5; e++) begin
      tick();
      vectors++;
      if (obs !== {4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL single_drive edge %0d: got %b want %b", e, obs, {4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0});
      end
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (obs !== {4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_turn: got %b want %b", obs, {4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0});
    end
    tick();
    vectors++;
    if (obs !== {4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_idle: got %b want %b", obs, {4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_setup_abort();
    req = 4'b0010;
    tick();
    vectors++;
    if (obs !== {4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_setup: got %b want %b", obs, {4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0});
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (obs !== {4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_turn: got %b want %b", obs, {4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0});
    end
    tick();
    vectors++;
    if (obs !== {4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_idle: got %b want %b", obs, {4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] oh;
    logic [1:0] o;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      o  = 2'(k % 4);
      oh = 4'b0001 << o;
      tick();
      vectors++;
      if (obs !== {oh, 4'b0000, o, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL rr_setup grant %0d: got %b want %b", k, obs, {oh, 4'b0000, o, 1'b1, 1'b0});
      end
      for (int c = 0; c < 16; c++) begin
        tick();
        vectors++;
        if (obs !== {oh, oh, o, 1'b1, 1'b0}) begin
          miscompares++;
          $display("FAIL rr_drive grant %0d cycle %0d: got %b want %b", k, c, obs, {oh, oh, o, 1'b1, 1'b0});
        end
      end
      tick();
      vectors++;
      if (obs !== {4'b0000, 4'b0000, o, 1'b1, 1'b1}) begin
        miscompares++;
        $display("FAIL rr_timeout grant %0d: got %b want %b", k, obs, {4'b0000, 4'b0000, o, 1'b1, 1'b1});
      end
      tick();
      vectors++;
      if (obs !== {4'b0000, 4'b0000, o, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL rr_idle grant %0d: got %b want %b", k, obs, {4'b0000, 4'b0000, o, 1'b0, 1'b0});
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    req = 4'b1000;
    tick();
    vectors++;
    if (obs !== {4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL ar_setup: got %b want %b", obs, {4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0});
    end
    tick();
    tick();
    vectors++;
    if (obs !== {4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL ar_drive: got %b want %b", obs, {4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});
    end
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (obs !== 12'b0) begin
      miscompares++;
      $display("FAIL ar_immediate: got %b want %b", obs, 12'b0);
    end
    tick();
    rst = 1'b0;
    req = 4'b1001;
    tick();
    vectors++;
    if (obs !== {4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL ar_regrant: got %b want %b", obs, {4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0});
    end
    tick();
    vectors++;
    if (obs !== {4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL ar_redrive: got %b want %b", obs, {4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0});
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    req4 = 4'b0100;
    for (int g = 0; g < 2; g++) begin
      tick();
      vectors++;
      if (obs4 !== {4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL to_setup pass %0d: got %b want %b", g, obs4, {4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0});
      end
      for (int c = 0; c < 4; c++) begin
        tick();
        vectors++;
        if (obs4 !== {4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0}) begin
          miscompares++;
          $display("FAIL to_drive pass %0d cycle %0d: got %b want %b", g, c, obs4, {4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
        end
      end
      // Second pass releases on the final hold cycle: normal release, no timeout.
      if (g == 1) req4 = 4'b0000;
      tick();
      vectors++;
      if (obs4 !== {4'b0000, 4'b0000, 2'd2, 1'b1, (g == 0)}) begin
        miscompares++;
        $display("FAIL to_turn pass %0d: got %b want %b", g, obs4, {4'b0000, 4'b0000, 2'd2, 1'b1, (g == 0)});
      end
      tick();
      vectors++;
      if (obs4 !== {4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL to_idle pass %0d: got %b want %b", g, obs4, {4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_setup_abort();
    test_round_robin();
    test_async_reset();
    test_timeout();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
